// File: rtl/post_box_spi_slave.sv
// SPI mode-0 slave for the POST-box host link: one status byte then one data byte per
// transaction, moving single bytes through the rx (target->host) and tx (host->target) mailboxes.
//   state    | meaning
//   S_IDLE   | CS high, or CS held low since reset; waiting for a CS falling edge
//   S_ACTIVE | transaction in progress, shifting bits on SCK edges
//   S_COMMIT | one cycle after CS rose with 16 bits seen; mailboxes update, txn_done high
module post_box_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       fpga_clock_48mhz,
    input  logic       reset_in,
    input  logic       spi_cs,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       rx_write,
    input  logic [7:0] rx_wdata,
    output logic       rx_full,
    input  logic       tx_read,
    input  logic       tx_clear,
    output logic [7:0] tx_rdata,
    output logic       tx_full,
    output logic       txn_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_mosi_sync;
    logic        r_cs_d, r_sck_d;
    logic        w_cs, w_sck, w_mosi;
    logic        w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
    logic        w_start, w_commit;

    logic [4:0]  r_bit_cnt;
    logic [9:0]  r_mosi_sh;
    logic [14:0] r_miso_sh;
    logic        r_miso;
    logic        r_snap_rx_full, r_snap_tx_empty;
    logic [15:0] w_word;

    logic        r_rx_full, r_tx_full;
    logic [7:0]  r_rx_buf, r_tx_data;

    // CS synchroniser resets low so a CS held low through reset shows no falling edge.
    always_ff @(posedge fpga_clock_48mhz or posedge reset_in) begin
        if (reset_in) begin
            r_cs_sync   <= '0;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b0;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_d      <= w_cs;
            r_sck_d     <= w_sck;
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_d & ~w_cs;
    assign w_cs_rise  = ~r_cs_d & w_cs;
    assign w_sck_rise = ~r_sck_d & w_sck;
    assign w_sck_fall = r_sck_d & ~w_sck;

    always_ff @(posedge fpga_clock_48mhz or posedge reset_in) begin
        if (reset_in) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_next  = S_ACTIVE;
                    w_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) w_next = (r_bit_cnt == 5'd16) ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_word = {6'b0, r_rx_full, ~r_tx_full, (r_rx_full ? r_rx_buf : 8'h00)};

    // Only the last 10 MOSI bits matter: host flags [9:8] and the data byte [7:0].
    always_ff @(posedge fpga_clock_48mhz or posedge reset_in) begin
        if (reset_in) begin
            r_bit_cnt       <= '0;
            r_mosi_sh       <= '0;
            r_miso_sh       <= '0;
            r_miso          <= 1'b0;
            r_snap_rx_full  <= 1'b0;
            r_snap_tx_empty <= 1'b0;
        end else if (w_start) begin
            r_bit_cnt       <= '0;
            r_snap_rx_full  <= r_rx_full;
            r_snap_tx_empty <= ~r_tx_full;
            r_miso_sh       <= w_word[14:0];
            r_miso          <= w_word[15];
        end else if (r_state == S_ACTIVE && !w_cs_rise) begin
            if (w_sck_rise && r_bit_cnt != 5'd16) begin
                r_mosi_sh <= {r_mosi_sh[8:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_sck_fall) begin
                r_miso_sh <= {r_miso_sh[13:0], 1'b0};
                r_miso    <= r_miso_sh[14];
            end
        end else begin
            r_miso <= 1'b0;
        end
    end

    // A commit clearing rx_full implies rx_full was already set, so a same-cycle write is dropped anyway.
    always_ff @(posedge fpga_clock_48mhz or posedge reset_in) begin
        if (reset_in) begin
            r_rx_full <= 1'b0;
            r_rx_buf  <= '0;
            r_tx_full <= 1'b0;
            r_tx_data <= '0;
        end else begin
            if (w_commit && r_mosi_sh[8] && r_snap_rx_full) begin
                r_rx_full <= 1'b0;
            end else if (rx_write && !r_rx_full) begin
                r_rx_buf  <= rx_wdata;
                r_rx_full <= 1'b1;
            end
            if (w_commit && r_mosi_sh[9] && r_snap_tx_empty) begin
                r_tx_data <= r_mosi_sh[7:0];
                r_tx_full <= 1'b1;
            end else if (tx_read || tx_clear) begin
                r_tx_full <= 1'b0;
            end
        end
    end

    assign spi_miso = r_miso;
    assign rx_full  = r_rx_full;
    assign tx_full  = r_tx_full;
    assign tx_rdata = r_tx_data;
    assign txn_done = (r_state == S_COMMIT);

endmodule
